pcihellocore_led_pio_blink: RTL and testbench
=============================================

// Module: pcihellocore_led_pio_blink
// PURPOSE
//  Avalon-MM slave output PIO for board LEDs, WIDTH bits wide.
//  Adds atomic SET/CLR write ports and a per-bit hardware blink mode driven by a programmable half-period counter.
//  Sits on the PCI bridge's Avalon bus in place of a plain output PIO; out_port drives LED pins directly.
// PARAMETERS
//  WIDTH      32  output port width, 1..32
//  PERIOD_W   24  width of half-period register and counter, 1..32
//  RESET_VAL  0   reset value of DATA register (WIDTH bits)
// PORTS
//  clk         in   1         clock
//  reset_n     in   1         asynchronous active-low reset
//  address     in   3         word address of register
//  chipselect  in   1         slave select
//  write_n     in   1         active-low write strobe, valid with chipselect
//  writedata   in   32        write data; bits above WIDTH ignored
//  readdata    out  32        read data, zero-extended above WIDTH
//  out_port    out  WIDTH     LED drive
//  blink_phase out  1         current blink phase (1 = blinking bits forced off)
// BEHAVIOUR
//  Register map (word addresses):
//   0 DATA   RW  data_out[WIDTH-1:0]
//   1 BLINK  RW  blink_en[WIDTH-1:0]; 1 = bit follows blink phase
//   2 PERIOD RW  period[PERIOD_W-1:0], half-period in clk cycles; 0 = blink off
//   3 SET    W   data_out <= data_out | wdata; reads 0
//   4 CLR    W   data_out <= data_out & ~wdata; reads 0
//   5 STATUS R   bit0 = blink_phase, others 0; writes ignored
//   6,7          read 0, writes ignored
//  Write: chipselect && !write_n; register updates on that rising clk edge.
//  Read: readdata is combinational from address (zero wait states); chipselect not required for the read mux.
//  Reset (async): data_out=RESET_VAL, blink_en=0, period=0, cnt=0, blink_phase=0
//   -> out_port=RESET_VAL, readdata per mux.
//  out_port = data_out & ~(blink_en & {WIDTH{blink_phase}}), combinational from registers.
//  Blink counter, PERIOD_W bits, per clk edge:
//   - PERIOD write this cycle: cnt<=0, blink_phase<=0 (write wins over terminal count).
//   - else period==0: cnt<=0, blink_phase<=0.
//   - else cnt==period-1: cnt<=0, blink_phase toggles.
//   - else cnt<=cnt+1.
//   -> with period=N, phase toggles every N cycles.
//   -> period=1 toggles every cycle; cnt never exceeds period-1.
//  SET/CLR are read-modify-write in one cycle; writedata bits above WIDTH are ignored.
//  Blink state and DATA are independent.
//   -> Clearing a BLINK bit restores that bit to data_out immediately.
//  Reset asserted mid-count returns to the reset state immediately; counting restarts from 0 after release.
// TESTING
//  1 Reset with RESET_VAL=0x0F, WIDTH=8 -> out_port=0x0F, read addr0=0x0F, addr1=0, addr2=0, addr5=0.
//  2 Write DATA=0xA5; then SET 0x0A; then CLR 0x81.
//    -> out_port 0xA5, then 0xAF, then 0x2E; reads of addr3/4 return 0.
//  3 DATA=0xFF, BLINK=0x0F, PERIOD=3 -> out_port alternates 0xFF/0xF0 every 3 clks.
//    -> first change exactly 3 clks after the PERIOD write edge.
//  4 Mid-blink, with phase=1, write PERIOD=5 -> same edge phase=0, out_port=0xFF.
//    -> next toggle 5 clks later.
//  5 Write PERIOD=0 while blinking -> phase held 0, out_port=data_out, STATUS=0 indefinitely.
//  6 Pulse reset_n low asynchronously mid-count with phase=1.
//    -> out_port=RESET_VAL without a clk edge; no toggles until PERIOD rewritten.

Source files
------------

// File: rtl/pcihellocore_led_pio_blink.sv
// Avalon-MM output PIO for board LEDs with atomic SET/CLR ports and
// per-bit hardware blink driven by a programmable half-period counter.
module pcihellocore_led_pio_blink #(
  parameter int unsigned             WIDTH     = 32,
  parameter int unsigned             PERIOD_W  = 24,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             blink_phase
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_BLINK  = 3'd1,
    ADDR_PERIOD = 3'd2,
    ADDR_SET    = 3'd3,
    ADDR_CLR    = 3'd4,
    ADDR_STATUS = 3'd5
  } addr_e;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;

  logic                w_wr;
  logic [WIDTH-1:0]    w_wdata;
  logic                w_period_wr;

  assign w_wr        = chipselect & ~write_n;
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);

  // NOTE: sequential state uses non-blocking assignments and an async
  // active-low reset in the sensitivity list, so every register clears
  // the moment reset_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VAL;
      r_blink  <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (addr_e'(address))
        ADDR_DATA:   r_data   <= w_wdata;
        ADDR_BLINK:  r_blink  <= w_wdata;
        ADDR_PERIOD: r_period <= writedata[PERIOD_W-1:0];
        ADDR_SET:    r_data   <= r_data | w_wdata;
        ADDR_CLR:    r_data   <= r_data & ~w_wdata;
        default:     ;
      endcase
    end
  end

  // A PERIOD write restarts the half-period even on a terminal-count edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_period_wr || (r_period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_period - PERIOD_W'(1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PERIOD_W'(1);
    end
  end

  // NOTE: readdata gets its default before the case so no path infers a latch.
  always_comb begin
    readdata = '0;
    case (addr_e'(address))
      ADDR_DATA:   readdata[WIDTH-1:0]    = r_data;
      ADDR_BLINK:  readdata[WIDTH-1:0]    = r_blink;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = r_period;
      ADDR_STATUS: readdata[0]            = r_phase;
      default:     ;
    endcase
  end

  assign out_port    = r_data & ~(r_blink & {WIDTH{r_phase}});
  assign blink_phase = r_phase;

endmodule

// File: tb/tb_pcihellocore_led_pio_blink.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized bus traffic compared every cycle against a behavioural model.
module tb_pcihellocore_led_pio_blink;

  localparam int unsigned      WIDTH     = 8;
  localparam int unsigned      PERIOD_W  = 8;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h0F;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             blink_phase;

  int checks = 0;
  int failures = 0;

  pcihellocore_led_pio_blink #(
    .WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase is derived from edges elapsed since the blink
  // was last restarted, divided by the half-period.
  logic [WIDTH-1:0] m_data, m_blink;
  int               m_period, m_k;

  function automatic logic m_phase();
    if (m_period == 0) return 1'b0;
    return ((m_k / m_period) % 2) == 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RESET_VAL; m_blink = '0; m_period = 0; m_k = 0;
    end else begin
      logic wr;
      wr = chipselect && !write_n;
      if (wr && address == 3'd2) begin
        m_period = int'(writedata[PERIOD_W-1:0]);
        m_k = 0;
      end else if (m_period == 0) m_k = 0;
      else m_k++;
      if (wr) begin
        case (address)
          3'd0: m_data = writedata[WIDTH-1:0];
          3'd1: m_blink = writedata[WIDTH-1:0];
          3'd3: m_data = m_data | writedata[WIDTH-1:0];
          3'd4: m_data = m_data & ~writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic [31:0] exp_rd;
      logic        ph;
      ph = m_phase();
      case (address)
        3'd0: exp_rd = 32'(m_data);
        3'd1: exp_rd = 32'(m_blink);
        3'd2: exp_rd = 32'(m_period);
        3'd5: exp_rd = {31'd0, ph};
        default: exp_rd = '0;
      endcase
      check("model_out_port", 32'(out_port), 32'(m_data & ~(m_blink & {WIDTH{ph}})));
      check("model_phase", 32'(blink_phase), 32'(ph));
      check("model_readdata", readdata, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  ra [4] = '{3'd0, 3'd1, 3'd2, 3'd5};
    logic [31:0] rv [4] = '{32'h0F, 32'h0, 32'h0, 32'h0};
    #12 reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_out_port", 32'(out_port), 32'h0F);
    for (int i = 0; i < 4; i++) begin
      address = ra[i]; tick();
      check("rst_read", readdata, rv[i]);
    end

    // DATA / SET / CLR, upper writedata bits ignored
    wr(3'd0, 32'hFFFF_FFA5); check("data_wr", 32'(out_port), 32'hA5);
    wr(3'd3, 32'h1234_560A); check("set_wr", 32'(out_port), 32'hAF);
    wr(3'd4, 32'h0000_0081); check("clr_wr", 32'(out_port), 32'h2E);
    address = 3'd3; #1 check("read_set", readdata, 32'h0);
    address = 3'd4; #1 check("read_clr", readdata, 32'h0);

    // Blink with half-period 3
    wr(3'd0, 32'hFF); wr(3'd1, 32'h0F); wr(3'd2, 32'd3);
    check("blink_start", 32'(out_port), 32'hFF);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("blink_p3", 32'(out_port), (i >= 3 && i < 6) ? 32'hF0 : 32'hFF);
    end

    // Rewrite PERIOD while phase=1
    repeat (3) tick();
    check("phase_before_rewrite", 32'(blink_phase), 32'h1);
    wr(3'd2, 32'd5);
    check("rewrite_phase", 32'(blink_phase), 32'h0);
    check("rewrite_out", 32'(out_port), 32'hFF);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("blink_p5", 32'(out_port), (i == 5) ? 32'hF0 : 32'hFF);
    end

    // Clearing a BLINK bit restores it immediately
    wr(3'd1, 32'h0E);
    check("blink_bit_clear", 32'(out_port), 32'hF1);

    // PERIOD=0 stops blinking
    wr(3'd2, 32'd0);
    address = 3'd5;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("period0_out", 32'(out_port), 32'hFF);
      check("period0_status", readdata, 32'h0);
    end

    // Async reset mid-count with phase=1
    wr(3'd1, 32'h0F); wr(3'd2, 32'd4);
    repeat (5) tick();
    check("pre_reset_phase", 32'(blink_phase), 32'h1);
    reset_n = 1'b0;
    #1 check("async_rst_out", 32'(out_port), 32'h0F);
    check("async_rst_phase", 32'(blink_phase), 32'h0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_out", 32'(out_port), 32'h0F);
    end

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        if (a == 3'd2) d[7:0] = 8'($urandom_range(0, 6));
        address = a; writedata = d;
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        address = 3'($urandom_range(0, 7));
        writedata = d;
        chipselect = 1'($urandom_range(0, 1));
        write_n = 1'b1;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
